// File: rtl/maze_solver.sv
// Depth-first maze walker: drives the 2^N x 2^N wall/visited bit memory,
// keeps the current path on a move stack, and replays the solution as
// 2-bit moves through a valid/ready handshake.
module maze_solver #(
  parameter int N     = 4,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] X,
  output logic [N-1:0] Y,
  output logic         D_in,
  output logic         RD,
  output logic         WR,
  input  logic         D_out,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [7:0]   path_len,
  output logic [1:0]   move,
  output logic         move_valid,
  input  logic         move_ready
);

  localparam int SPW = $clog2(DEPTH);
  localparam logic [N-1:0]   MAXC = '1;
  localparam logic [N-1:0]   ONE  = 1;
  localparam logic [SPW-1:0] SP1  = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_READ0, S_CHECK0, S_MARK, S_TRY, S_READ, S_CHECK,
    S_BACK, S_DONE, S_REPLAY, S_FAIL
  } state_t;

  state_t         state;
  logic [N-1:0]   cur_x, cur_y;
  logic [2:0]     k;
  logic [SPW-1:0] sp, rptr, rptr_n;
  logic [1:0]     stack [DEPTH];

  logic [N-1:0]   nb_x, nb_y, bk_x, bk_y;
  logic           nb_ok;
  logic [1:0]     top_k;

  // k order: 0 right, 1 down, 2 left, 3 up -> replay codes 01, 11, 10, 00
  function automatic logic [1:0] dir_code(input logic [1:0] d);
    case (d)
      2'd0:    dir_code = 2'b01;
      2'd1:    dir_code = 2'b11;
      2'd2:    dir_code = 2'b10;
      default: dir_code = 2'b00;
    endcase
  endfunction

  // Candidate neighbour in direction k, with edge check (no wrap-around)
  always_comb begin
    nb_x  = cur_x;
    nb_y  = cur_y;
    nb_ok = 1'b0;
    case (k[1:0])
      2'd0: begin nb_x = cur_x + ONE; nb_ok = (cur_x != MAXC); end
      2'd1: begin nb_y = cur_y + ONE; nb_ok = (cur_y != MAXC); end
      2'd2: begin nb_x = cur_x - ONE; nb_ok = (cur_x != '0);   end
      default: begin nb_y = cur_y - ONE; nb_ok = (cur_y != '0); end
    endcase
  end

  // Backtrack step: undo the move on top of the stack
  always_comb begin
    top_k = stack[sp - SP1];
    bk_x  = cur_x;
    bk_y  = cur_y;
    case (top_k)
      2'd0:    bk_x = cur_x - ONE;
      2'd1:    bk_y = cur_y - ONE;
      2'd2:    bk_x = cur_x + ONE;
      default: bk_y = cur_y + ONE;
    endcase
  end

  // Address shows the probed neighbour from TRY through CHECK so it is
  // settled a full cycle before RD rises; otherwise it shows the current cell.
  assign X        = (state == S_TRY || state == S_READ || state == S_CHECK) ? nb_x : cur_x;
  assign Y        = (state == S_TRY || state == S_READ || state == S_CHECK) ? nb_y : cur_y;
  assign D_in     = 1'b1;
  assign path_len = 8'(sp);
  assign rptr_n   = rptr + SP1;

  // Move stack: push the successful direction when an open neighbour is found
  always_ff @(posedge clk) begin
    if (state == S_CHECK && !D_out) stack[sp] <= k[1:0];
  end

  // Solver / replay FSM with registered strobes and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      k          <= '0;
      sp         <= '0;
      rptr       <= '0;
      RD         <= 1'b0;
      WR         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      move       <= 2'b00;
      move_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          done  <= 1'b0;
          fail  <= 1'b0;
          sp    <= '0;
          cur_x <= '0;
          cur_y <= '0;
          busy  <= 1'b1;
          RD    <= 1'b1;
          state <= S_READ0;
        end
        S_READ0: state <= S_CHECK0;
        S_CHECK0: begin
          RD <= 1'b0;
          if (D_out) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            WR    <= 1'b1;
            state <= S_MARK;
          end
        end
        S_MARK: begin
          WR <= 1'b0;
          if (cur_x == MAXC && cur_y == MAXC) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            k     <= '0;
            state <= S_TRY;
          end
        end
        S_TRY: begin
          if (k[2])       state <= S_BACK;
          else if (nb_ok) begin
            RD    <= 1'b1;
            state <= S_READ;
          end else        k <= k + 3'd1;
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          RD <= 1'b0;
          if (!D_out) begin
            sp    <= sp + SP1;
            cur_x <= nb_x;
            cur_y <= nb_y;
            WR    <= 1'b1;
            state <= S_MARK;
          end else begin
            k     <= k + 3'd1;
            state <= S_TRY;
          end
        end
        S_BACK: begin
          if (sp == '0) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            sp    <= sp - SP1;
            cur_x <= bk_x;
            cur_y <= bk_y;
            k     <= {1'b0, top_k} + 3'd1;
            state <= S_TRY;
          end
        end
        S_DONE: begin
          rptr       <= '0;
          move       <= dir_code(stack[0]);
          move_valid <= (sp != '0);
          state      <= S_REPLAY;
        end
        S_REPLAY: begin
          if (!move_valid) begin
            cur_x <= '0;
            cur_y <= '0;
            state <= S_IDLE;
          end else if (move_ready) begin
            rptr <= rptr_n;
            if (rptr_n == sp) begin
              move_valid <= 1'b0;
              cur_x      <= '0;
              cur_y      <= '0;
              state      <= S_IDLE;
            end else begin
              move <= dir_code(stack[rptr_n]);
            end
          end
        end
        S_FAIL: begin
          cur_x <= '0;
          cur_y <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver: behavioural 16x16 bit memory, protocol
// monitor, and one task per scenario.
module tb_maze_solver;

  logic       clk = 1'b0;
  logic       rst_n, start, D_out, move_ready;
  logic [3:0] X, Y;
  logic       D_in, RD, WR, busy, done, fail, move_valid;
  logic [7:0] path_len;
  logic [1:0] move;

  int tests = 0;
  int fails = 0;

  maze_solver #(.N(4), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y), .D_in(D_in),
    .RD(RD), .WR(WR), .D_out(D_out), .busy(busy), .done(done), .fail(fail),
    .path_len(path_len), .move(move), .move_valid(move_valid),
    .move_ready(move_ready)
  );

  always #5 clk = ~clk;

  // Memory model: index {Y,X}; loaded from maze_init on a load pulse
  logic [255:0] mem;
  logic [255:0] maze_init = '0;
  logic         load = 1'b0;
  int           wrcnt [256];
  int           wr_total = 0;

  assign D_out = mem[{Y, X}];

  always @(posedge clk) begin
    if (load) begin
      mem = maze_init;
      for (int i = 0; i < 256; i++) wrcnt[i] = 0;
      wr_total = 0;
    end else if (WR) begin
      mem[{Y, X}] = 1'b1;
      wrcnt[{Y, X}] = wrcnt[{Y, X}] + 1;
      wr_total = wr_total + 1;
    end
  end

  // Protocol monitor: no RD&WR overlap, address held from the cycle before a strobe
  int       proto_err = 0;
  logic [7:0] prev_xy = '0;
  always @(negedge clk) begin
    if (RD && WR) proto_err = proto_err + 1;
    if ((RD || WR) && ({X, Y} != prev_xy)) proto_err = proto_err + 1;
    prev_xy = {X, Y};
  end

  logic [1:0] got [64];
  int         got_n;
  int         stall_err;
  bit         coll_timeout;

  task automatic load_maze(input logic [255:0] m);
    @(negedge clk);
    maze_init = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok, output int pk, output bit ret0);
    ok = 0; pk = 0; ret0 = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!ret0) begin
        if (int'(path_len) > pk) pk = int'(path_len);
        else if (pk > 0 && path_len == 8'd0) ret0 = 1;
      end
      if (done || fail) begin ok = 1; break; end
    end
  endtask

  // Drains the replay stream; toggle=1 applies the ready pattern 1,0,0,1
  task automatic collect(input bit toggle);
    logic [3:0] pat;
    logic [1:0] held_m;
    bit seen, held, rdy;
    int pi;
    pat = 4'b1001;
    got_n = 0; stall_err = 0; seen = 0; held = 0; pi = 0; held_m = 2'b00;
    coll_timeout = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (held && (!move_valid || move !== held_m)) stall_err++;
      if (!move_valid) begin
        held = 0;
        if (seen) begin coll_timeout = 0; break; end
      end else begin
        seen = 1;
        rdy = toggle ? pat[pi % 4] : 1'b1;
        pi++;
        move_ready = rdy;
        if (rdy) begin
          if (got_n < 64) got[got_n] = move;
          got_n++;
          held = 0;
        end else begin
          held = 1;
          held_m = move;
        end
      end
    end
    move_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; move_ready = 1'b0;
    #1;
    tests++;
    if ({X, Y, D_in, RD, WR, busy, done, fail, path_len, move, move_valid} !==
        {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got X=%0d Y=%0d Din=%0b RD=%0b WR=%0b busy=%0b done=%0b fail=%0b len=%0d mv=%0d mvv=%0b expected 0 0 1 0 0 0 0 0 0 0 0",
               X, Y, D_in, RD, WR, busy, done, fail, path_len, move, move_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_open();
    bit ok, r0; int pk, bad;
    load_maze('0);
    pulse_start();
    wait_end(5000, ok, pk, r0);
    tests++;
    if (!(ok && done && !fail && !busy)) begin
      fails++; $display("FAIL open_done: got ok=%0b done=%0b fail=%0b busy=%0b expected 1 1 0 0", ok, done, fail, busy);
    end
    tests++;
    if (path_len !== 8'd30) begin fails++; $display("FAIL open_len: got %0d expected 30", path_len); end
    collect(1'b0);
    bad = 0;
    for (int i = 0; i < 30; i++) if (got[i] !== (i < 15 ? 2'b01 : 2'b11)) bad++;
    tests++;
    if (coll_timeout || got_n != 30 || bad != 0) begin
      fails++; $display("FAIL open_replay: got count=%0d bad=%0d timeout=%0b expected 30 0 0", got_n, bad, coll_timeout);
    end
    tests++;
    if (!(done && !move_valid && !busy)) begin
      fails++; $display("FAIL open_after_replay: got done=%0b mvv=%0b busy=%0b expected 1 0 0", done, move_valid, busy);
    end
  endtask

  task automatic test_start_wall();
    bit seen;
    logic [255:0] m;
    m = '0; m[0] = 1'b1;
    load_maze(m);
    pulse_start();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (fail) begin seen = 1; break; end
      @(negedge clk);
    end
    if (fail) seen = 1;
    tests++;
    if (!seen) begin fails++; $display("FAIL wall_fail_latency: got fail=%0b expected 1 within 4 cycles", fail); end
    tests++;
    if (wr_total != 0 || path_len !== 8'd0 || done || busy) begin
      fails++; $display("FAIL wall_state: got writes=%0d len=%0d done=%0b busy=%0b expected 0 0 0 0", wr_total, path_len, done, busy);
    end
  endtask

  task automatic test_no_path();
    bit ok, r0; int pk, bad;
    logic [255:0] m;
    m = '0;
    m[{4'd15, 4'd14}] = 1'b1;
    m[{4'd14, 4'd15}] = 1'b1;
    load_maze(m);
    pulse_start();
    wait_end(30000, ok, pk, r0);
    tests++;
    if (!(ok && fail && !done && !busy && path_len == 8'd0)) begin
      fails++; $display("FAIL nopath_end: got ok=%0b fail=%0b done=%0b busy=%0b len=%0d expected 1 1 0 0 0", ok, fail, done, busy, path_len);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255 || i == {4'd15, 4'd14} || i == {4'd14, 4'd15}) begin
        if (wrcnt[i] != 0) bad++;
      end else if (wrcnt[i] != 1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL nopath_marks: got %0d cells with wrong write count expected 0", bad); end
  endtask

  task automatic test_dead_end();
    bit ok, r0; int pk, bad;
    logic [255:0] m;
    m = '1;
    for (int x = 0; x <= 5; x++) m[x] = 1'b0;
    for (int y = 0; y < 16; y++) m[y * 16] = 1'b0;
    for (int x = 0; x < 16; x++) m[240 + x] = 1'b0;
    load_maze(m);
    pulse_start();
    wait_end(5000, ok, pk, r0);
    tests++;
    if (!(r0 && pk == 5)) begin fails++; $display("FAIL deadend_backtrack: got peak=%0d returned0=%0b expected 5 1", pk, r0); end
    tests++;
    if (!(ok && done && path_len == 8'd30)) begin
      fails++; $display("FAIL deadend_done: got done=%0b len=%0d expected 1 30", done, path_len);
    end
    collect(1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) if (got[i] !== (i < 15 ? 2'b11 : 2'b01)) bad++;
    tests++;
    if (coll_timeout || got_n != int'(path_len) || bad != 0) begin
      fails++; $display("FAIL deadend_replay: got count=%0d bad=%0d timeout=%0b expected 30 0 0", got_n, bad, coll_timeout);
    end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL deadend_stall: got %0d unstable stalls expected 0", stall_err); end
  endtask

  task automatic test_back_to_back();
    bit ok, r0, hit; int pk, bad;
    load_maze('0);
    pulse_start();
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (RD && path_len >= 8'd2) begin hit = 1; break; end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (!hit || RD || WR || busy) begin
      fails++; $display("FAIL midreset: got hit=%0b RD=%0b WR=%0b busy=%0b expected 1 0 0 0", hit, RD, WR, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_maze('0);
    pulse_start();
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (path_len >= 8'd3) begin hit = 1; break; end
    end
    pulse_start();
    @(negedge clk);
    tests++;
    if (!hit || path_len < 8'd3 || !busy) begin
      fails++; $display("FAIL busy_start_ignored: got len=%0d busy=%0b expected >=3 1", path_len, busy);
    end
    wait_end(5000, ok, pk, r0);
    tests++;
    if (!(ok && done && path_len == 8'd30)) begin
      fails++; $display("FAIL resolve_done: got done=%0b len=%0d expected 1 30", done, path_len);
    end
    collect(1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) if (got[i] !== (i < 15 ? 2'b01 : 2'b11)) bad++;
    tests++;
    if (coll_timeout || got_n != 30 || bad != 0 || stall_err != 0 || move_valid) begin
      fails++; $display("FAIL resolve_replay: got count=%0d bad=%0d stall=%0d mvv=%0b expected 30 0 0 0", got_n, bad, stall_err, move_valid);
    end
    tests++;
    if (proto_err != 0) begin fails++; $display("FAIL mem_protocol: got %0d violations expected 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_all_open();
    test_start_wall();
    test_no_path();
    test_dead_end();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
